// File: rtl/mops_sdo_pkg.sv
// mops_sdo_pkg
// Shared definitions for the emulated MOPS SDO responder:
//   - responder state and object-dictionary action enums
//   - CAN frame field positions (76-bit frame: COB-ID, RTR, bytes 0..7)
//   - SDO command specifiers, abort codes and object-dictionary indices
//   - le32: byte swap between a 32-bit value and CAN bytes 4..7 order
package mops_sdo_pkg;

    // Frame layout: [75:65] COB-ID, [64] RTR, [63:0] bytes 0..7 (byte0 at [63:56])
    localparam int FRAME_W    = 76;
    localparam int COB_HI     = 75;
    localparam int COB_LO     = 65;
    localparam int RTR_BIT    = 64;
    localparam int BYTE0_HI   = 63;
    localparam int BYTE1_HI   = 55;
    localparam int BYTE2_HI   = 47;
    localparam int BYTE3_HI   = 39;
    localparam int PAYLOAD_HI = 31;

    localparam logic [10:0] COB_REQ_BASE = 11'h600;
    localparam logic [10:0] COB_RSP_BASE = 11'h580;

    // SDO command specifiers
    localparam logic [7:0] CMD_UPLOAD_REQ   = 8'h40;
    localparam logic [7:0] CMD_DOWNLOAD4    = 8'h23;
    localparam logic [7:0] CMD_RSP_UPLOAD4  = 8'h43;
    localparam logic [7:0] CMD_RSP_UPLOAD2  = 8'h4B;
    localparam logic [7:0] CMD_RSP_UPLOAD1  = 8'h4F;
    localparam logic [7:0] CMD_RSP_DOWNLOAD = 8'h60;
    localparam logic [7:0] CMD_RSP_ABORT    = 8'h80;

    // SDO abort codes
    localparam logic [31:0] ABORT_BAD_CMD   = 32'h0504_0001;
    localparam logic [31:0] ABORT_NO_INDEX  = 32'h0602_0000;
    localparam logic [31:0] ABORT_BAD_SUB   = 32'h0609_0011;
    localparam logic [31:0] ABORT_ADC_FAULT = 32'h0800_0000;

    // Object dictionary indices
    localparam logic [15:0] OD_IDX_ADC     = 16'h2400;
    localparam logic [15:0] OD_IDX_SCRATCH = 16'h2200;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECODE,
        ST_ADC_WAIT,
        ST_DELAY,
        ST_SEND
    } sdo_state_t;

    typedef enum logic [2:0] {
        ACT_ADC,
        ACT_CONST,
        ACT_SCR_RD,
        ACT_SCR_WR,
        ACT_ABORT
    } od_action_t;

    // CAN carries multi-byte values little-endian in bytes 4..7, but byte4
    // sits in the most significant position of the frame, so the mapping in
    // either direction is a plain byte reversal.
    function automatic logic [31:0] le32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/mops_od_lookup.sv
// mops_od_lookup
// Combinational object-dictionary decoder for the SDO responder.
// Ports:
//   cmd        in  8  : SDO command specifier (request byte0)
//   index      in  16 : object index
//   sub        in  8  : object sub-index
//   action     out    : what the responder must do with the request
//   abort_code out 32 : abort code, meaningful when action == ACT_ABORT
module mops_od_lookup
    import mops_sdo_pkg::*;
#(
    parameter logic [5:0] N_ADC_CH = 6'd35
) (
    input  logic [7:0]  cmd,
    input  logic [15:0] index,
    input  logic [7:0]  sub,
    output od_action_t  action,
    output logic [31:0] abort_code
);

    // Command validity is checked first, then the index, then the sub-index.
    // The ADC table is read-only, so a download to it is a command error.
    always_comb begin
        action     = ACT_ABORT;
        abort_code = 32'h0;
        if (cmd != CMD_UPLOAD_REQ && cmd != CMD_DOWNLOAD4) begin
            abort_code = ABORT_BAD_CMD;
        end else if (index == OD_IDX_ADC) begin
            if (cmd == CMD_DOWNLOAD4) begin
                abort_code = ABORT_BAD_CMD;
            end else if (sub == 8'd0) begin
                action = ACT_CONST;
            end else if (sub <= {2'b00, N_ADC_CH}) begin
                action = ACT_ADC;
            end else begin
                abort_code = ABORT_BAD_SUB;
            end
        end else if (index == OD_IDX_SCRATCH) begin
            if (sub != 8'd0) begin
                abort_code = ABORT_BAD_SUB;
            end else if (cmd == CMD_UPLOAD_REQ) begin
                action = ACT_SCR_RD;
            end else begin
                action = ACT_SCR_WR;
            end
        end else begin
            abort_code = ABORT_NO_INDEX;
        end
    end

endmodule

// File: rtl/mops_sdo_responder.sv
// mops_sdo_responder
// Emulated MOPS-side CANopen SDO responder (expedited upload/download).
// Ports:
//   clk, rst              : clock, asynchronous active-high reset
//   req_data/valid/ready  : incoming 76-bit CAN request frame
//   rsp_data/valid/ready  : outgoing 76-bit CAN response frame
//   adc_req/ch/ack/val    : ADC sample fetch handshake
//   busy                  : high whenever a transaction is in progress
//   abort_cnt             : saturating count of abort responses sent
module mops_sdo_responder
    import mops_sdo_pkg::*;
#(
    parameter logic [6:0]  NODE_ID     = 7'h3F,
    parameter logic [5:0]  N_ADC_CH    = 6'd35,
    parameter logic [15:0] RESP_DELAY  = 16'd8,
    parameter logic [15:0] ADC_TIMEOUT = 16'd1000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [FRAME_W-1:0]  req_data,
    input  logic                req_valid,
    output logic                req_ready,
    output logic [FRAME_W-1:0]  rsp_data,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic                adc_req,
    output logic [5:0]          adc_ch,
    input  logic                adc_ack,
    input  logic [11:0]         adc_val,
    output logic                busy,
    output logic [7:0]          abort_cnt
);

    localparam logic [10:0] COB_REQ = COB_REQ_BASE + {4'h0, NODE_ID};
    localparam logic [10:0] COB_RSP = COB_RSP_BASE + {4'h0, NODE_ID};

    // With no turnaround delay the DELAY state is skipped entirely so that
    // rsp_valid still rises two cycles after the accept.
    localparam sdo_state_t ST_AFTER_RSP = (RESP_DELAY == 16'd0) ? ST_SEND : ST_DELAY;

    sdo_state_t  state;
    sdo_state_t  state_nxt;
    logic [63:0] req_bytes;
    logic [31:0] scratch;
    logic [15:0] cnt;
    logic        rsp_is_abort;
    logic        req_match;
    logic        adc_timeout;
    logic [7:0]  req_cmd;
    logic [15:0] req_index;
    logic [7:0]  req_sub;
    od_action_t  od_action;
    logic [31:0] od_abort_code;

    assign req_cmd     = req_bytes[BYTE0_HI -: 8];
    assign req_index   = {req_bytes[BYTE2_HI -: 8], req_bytes[BYTE1_HI -: 8]};
    assign req_sub     = req_bytes[BYTE3_HI -: 8];
    assign req_match   = (req_data[COB_HI:COB_LO] == COB_REQ) && !req_data[RTR_BIT];
    assign adc_timeout = (cnt == ADC_TIMEOUT - 16'd1);

    assign req_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign rsp_valid = (state == ST_SEND);
    assign adc_req   = (state == ST_ADC_WAIT);

    mops_od_lookup #(
        .N_ADC_CH (N_ADC_CH)
    ) u_od_lookup (
        .cmd        (req_cmd),
        .index      (req_index),
        .sub        (req_sub),
        .action     (od_action),
        .abort_code (od_abort_code)
    );

    // Response template: node response COB-ID, RTR clear, bytes 1..3 echoed
    // from the request, payload placed little-endian in bytes 4..7.
    function automatic logic [FRAME_W-1:0] build_rsp(input logic [7:0]  byte0,
                                                     input logic [23:0] echo,
                                                     input logic [31:0] payload);
        return {COB_RSP, 1'b0, byte0, echo, le32(payload)};
    endfunction

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. Frames not addressed to this node (or remote frames)
    // are accepted and silently dropped so the bus never stalls on them.
    // In ADC_WAIT an ack takes precedence over the timeout on the same cycle.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (req_valid && req_match) begin
                    state_nxt = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (od_action == ACT_ADC) begin
                    state_nxt = ST_ADC_WAIT;
                end else begin
                    state_nxt = ST_AFTER_RSP;
                end
            end
            ST_ADC_WAIT: begin
                if (adc_ack || adc_timeout) begin
                    state_nxt = ST_AFTER_RSP;
                end
            end
            ST_DELAY: begin
                if (cnt == RESP_DELAY - 16'd1) begin
                    state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                if (rsp_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Shared cycle counter for the ADC timeout and the turnaround delay;
    // it restarts on every state change so each wait begins at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= 16'd0;
        end else if (state_nxt != state) begin
            cnt <= 16'd0;
        end else if (state == ST_ADC_WAIT || state == ST_DELAY) begin
            cnt <= cnt + 16'd1;
        end
    end

    // Datapath: request latch, response builder, scratch register, ADC
    // channel select and abort statistics.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_bytes    <= 64'h0;
            rsp_data     <= '0;
            scratch      <= 32'h0;
            adc_ch       <= 6'd0;
            rsp_is_abort <= 1'b0;
            abort_cnt    <= 8'h00;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        req_bytes <= req_data[BYTE0_HI:0];
                    end
                end
                ST_DECODE: begin
                    rsp_is_abort <= (od_action == ACT_ABORT);
                    unique case (od_action)
                        ACT_ADC: begin
                            adc_ch <= 6'(req_sub - 8'd1);
                        end
                        ACT_CONST: begin
                            rsp_data <= build_rsp(CMD_RSP_UPLOAD1, req_bytes[BYTE1_HI -: 24],
                                                  {26'h0, N_ADC_CH});
                        end
                        ACT_SCR_RD: begin
                            rsp_data <= build_rsp(CMD_RSP_UPLOAD4, req_bytes[BYTE1_HI -: 24], scratch);
                        end
                        ACT_SCR_WR: begin
                            scratch  <= le32(req_bytes[PAYLOAD_HI:0]);
                            rsp_data <= build_rsp(CMD_RSP_DOWNLOAD, req_bytes[BYTE1_HI -: 24], 32'h0);
                        end
                        default: begin
                            rsp_data <= build_rsp(CMD_RSP_ABORT, req_bytes[BYTE1_HI -: 24], od_abort_code);
                        end
                    endcase
                end
                ST_ADC_WAIT: begin
                    if (adc_ack) begin
                        rsp_data <= build_rsp(CMD_RSP_UPLOAD2, req_bytes[BYTE1_HI -: 24],
                                              {20'h0, adc_val});
                    end else if (adc_timeout) begin
                        rsp_data     <= build_rsp(CMD_RSP_ABORT, req_bytes[BYTE1_HI -: 24], ABORT_ADC_FAULT);
                        rsp_is_abort <= 1'b1;
                    end
                end
                ST_SEND: begin
                    if (rsp_ready && rsp_is_abort && abort_cnt != 8'hFF) begin
                        abort_cnt <= abort_cnt + 8'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mops_sdo_responder.sv
// tb_mops_sdo_responder
// Directed self-checking bench for mops_sdo_responder. Expected response
// frames are pushed to a scoreboard queue when a request is driven and
// popped when the responder completes its response handshake.
module tb_mops_sdo_responder;

    localparam logic [6:0]  NODE_ID     = 7'h3F;
    localparam logic [5:0]  N_ADC_CH    = 6'd35;
    localparam logic [15:0] RESP_DELAY  = 16'd8;
    localparam logic [15:0] ADC_TIMEOUT = 16'd1000;
    localparam int          D           = 8;
    localparam int          T           = 1000;

    logic        clk = 1'b0;
    logic        rst;
    logic [75:0] req_data;
    logic        req_valid;
    logic        req_ready;
    logic [75:0] rsp_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        adc_req;
    logic [5:0]  adc_ch;
    logic        adc_ack;
    logic [11:0] adc_val;
    logic        busy;
    logic [7:0]  abort_cnt;

    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    logic [75:0] expQ[$];

    mops_sdo_responder #(
        .NODE_ID     (NODE_ID),
        .N_ADC_CH    (N_ADC_CH),
        .RESP_DELAY  (RESP_DELAY),
        .ADC_TIMEOUT (ADC_TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_data  (req_data),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .rsp_data  (rsp_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .adc_req   (adc_req),
        .adc_ch    (adc_ch),
        .adc_ack   (adc_ack),
        .adc_val   (adc_val),
        .busy      (busy),
        .abort_cnt (abort_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Request payload: byte0=cmd, bytes1..2 index little-endian, byte3 sub,
    // bytes4..7 data little-endian.
    function automatic logic [63:0] reqBytes(input logic [7:0] cmd, input logic [15:0] idx,
                                             input logic [7:0] sub, input logic [31:0] data);
        return {cmd, idx[7:0], idx[15:8], sub, data[7:0], data[15:8], data[23:16], data[31:24]};
    endfunction

    // Response frame as seen from node 0x3F: COB-ID 0x5BF, RTR 0.
    function automatic logic [75:0] rspFrame(input logic [7:0] b0, input logic [15:0] idx,
                                             input logic [7:0] sub, input logic [31:0] data);
        return {11'h5BF, 1'b0, reqBytes(b0, idx, sub, data)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [75:0] observed, input logic [75:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_req_ready"}, 76'(req_ready), 76'(1));
        checkOutput({tag, "_rsp_valid"}, 76'(rsp_valid), 76'(0));
        checkOutput({tag, "_rsp_data"},  rsp_data,       76'(0));
        checkOutput({tag, "_adc_req"},   76'(adc_req),   76'(0));
        checkOutput({tag, "_adc_ch"},    76'(adc_ch),    76'(0));
        checkOutput({tag, "_busy"},      76'(busy),      76'(0));
        checkOutput({tag, "_abort_cnt"}, 76'(abort_cnt), 76'(0));
    endtask

    // Drives one request for a single cycle; acceptCyc is the handshake cycle.
    task automatic applyStimulus(input logic [10:0] cob, input logic rtr,
                                 input logic [63:0] bytes, output int acceptCyc);
        req_data  = {cob, rtr, bytes};
        req_valid = 1'b1;
        acceptCyc = cyc;
        checkOutput("req_ready_at_accept", 76'(req_ready), 76'(1));
        tick();
        req_valid = 1'b0;
        req_data  = '0;
    endtask

    // Plays the ADC side: acknowledges on the ackOn-th cycle of adc_req
    // (0 = never) and reports how long adc_req stayed high.
    task automatic runAdc(input int ackOn, input logic [11:0] val,
                          output int riseCyc, output int ackCyc, output int reqCycles);
        int n;
        n = 0;
        reqCycles = 0;
        ackCyc = -1;
        riseCyc = -1;
        while (!adc_req && n < 50) begin
            tick();
            n++;
        end
        checkOutput("adc_req_seen", 76'(adc_req), 76'(1));
        if (!adc_req) return;
        riseCyc = cyc;
        while (adc_req && reqCycles < 2000) begin
            reqCycles++;
            if (reqCycles == ackOn) begin
                adc_ack = 1'b1;
                adc_val = val;
                ackCyc  = cyc;
            end
            tick();
            adc_ack = 1'b0;
        end
    endtask

    // Waits for rsp_valid, optionally stalls rsp_ready, then completes the
    // handshake and compares the frame against the scoreboard head.
    task automatic waitRsp(input int holdLow, output int validCyc);
        int n;
        logic [75:0] exp;
        n = 0;
        validCyc = -1;
        while (!rsp_valid && n < 200) begin
            tick();
            n++;
        end
        checkOutput("rsp_valid_seen", 76'(rsp_valid), 76'(1));
        if (!rsp_valid) return;
        validCyc = cyc;
        if (expQ.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL scoreboard_empty observed=response expected=none");
            return;
        end
        exp = expQ.pop_front();
        for (int i = 0; i < holdLow; i++) begin
            tick();
            checkOutput("stall_rsp_data", rsp_data, exp);
            checkOutput("stall_rsp_valid", 76'(rsp_valid), 76'(1));
            checkOutput("stall_req_ready", 76'(req_ready), 76'(0));
        end
        rsp_ready = 1'b1;
        checkOutput("rsp_frame", rsp_data, exp);
        tick();
        rsp_ready = 1'b0;
        checkOutput("idle_after_send", 76'(busy), 76'(0));
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int acc, vc, rise, ack, nreq, seenValid, seenBusy;

        rst       = 1'b1;
        req_data  = '0;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        adc_ack   = 1'b0;
        adc_val   = 12'h0;
        tick();
        tick();
        checkResetValues("reset");
        rst = 1'b0;
        tick();

        // ADC upload sub 5, ack on the fourth cycle of adc_req.
        $display("[TB] ADC upload sub 5");
        expQ.push_back(rspFrame(8'h4B, 16'h2400, 8'h05, 32'h0000_0ABC));
        applyStimulus(11'h63F, 1'b0, reqBytes(8'h40, 16'h2400, 8'h05, 32'h0), acc);
        runAdc(4, 12'hABC, rise, ack, nreq);
        checkOutput("adc_req_rise_cycle", 76'(rise), 76'(acc + 2));
        checkOutput("adc_req_cycles", 76'(nreq), 76'(4));
        checkOutput("adc_ch_sub5", 76'(adc_ch), 76'(4));
        waitRsp(0, vc);
        checkOutput("adc_rsp_latency", 76'(vc), 76'(ack + D + 1));

        // Constant upload: channel count.
        $display("[TB] channel count upload");
        expQ.push_back(rspFrame(8'h4F, 16'h2400, 8'h00, 32'd35));
        applyStimulus(11'h63F, 1'b0, reqBytes(8'h40, 16'h2400, 8'h00, 32'h0), acc);
        waitRsp(0, vc);
        checkOutput("const_rsp_latency", 76'(vc), 76'(acc + 2 + D));

        // Scratch download then upload, the upload with a 20-cycle stall.
        $display("[TB] scratch download/upload");
        expQ.push_back(rspFrame(8'h60, 16'h2200, 8'h00, 32'h0));
        applyStimulus(11'h63F, 1'b0, reqBytes(8'h23, 16'h2200, 8'h00, 32'hDEAD_BEEF), acc);
        waitRsp(0, vc);
        checkOutput("download_latency", 76'(vc), 76'(acc + 2 + D));
        expQ.push_back(rspFrame(8'h43, 16'h2200, 8'h00, 32'hDEAD_BEEF));
        applyStimulus(11'h63F, 1'b0, reqBytes(8'h40, 16'h2200, 8'h00, 32'h0), acc);
        waitRsp(20, vc);

        // Abort paths.
        $display("[TB] abort responses");
        expQ.push_back(rspFrame(8'h80, 16'h1234, 8'h00, 32'h0602_0000));
        applyStimulus(11'h63F, 1'b0, reqBytes(8'h40, 16'h1234, 8'h00, 32'h0), acc);
        waitRsp(0, vc);
        checkOutput("abort_cnt_1", 76'(abort_cnt), 76'(1));
        expQ.push_back(rspFrame(8'h80, 16'h2400, 8'd36, 32'h0609_0011));
        applyStimulus(11'h63F, 1'b0, reqBytes(8'h40, 16'h2400, 8'd36, 32'h0), acc);
        waitRsp(0, vc);
        checkOutput("abort_cnt_2", 76'(abort_cnt), 76'(2));
        expQ.push_back(rspFrame(8'h80, 16'h2200, 8'h00, 32'h0504_0001));
        applyStimulus(11'h63F, 1'b0, reqBytes(8'h60, 16'h2200, 8'h00, 32'h0), acc);
        waitRsp(0, vc);
        checkOutput("abort_cnt_3", 76'(abort_cnt), 76'(3));

        // ADC timeout, then an ack landing on the timeout cycle.
        $display("[TB] ADC timeout");
        expQ.push_back(rspFrame(8'h80, 16'h2400, 8'h01, 32'h0800_0000));
        applyStimulus(11'h63F, 1'b0, reqBytes(8'h40, 16'h2400, 8'h01, 32'h0), acc);
        runAdc(0, 12'h0, rise, ack, nreq);
        checkOutput("timeout_adc_cycles", 76'(nreq), 76'(T));
        checkOutput("adc_ch_sub1", 76'(adc_ch), 76'(0));
        waitRsp(0, vc);
        checkOutput("timeout_rsp_latency", 76'(vc), 76'(rise + T + D));
        checkOutput("abort_cnt_4", 76'(abort_cnt), 76'(4));
        expQ.push_back(rspFrame(8'h4B, 16'h2400, 8'd35, 32'h0000_0123));
        applyStimulus(11'h63F, 1'b0, reqBytes(8'h40, 16'h2400, 8'd35, 32'h0), acc);
        runAdc(T, 12'h123, rise, ack, nreq);
        checkOutput("late_ack_cycles", 76'(nreq), 76'(T));
        checkOutput("adc_ch_sub35", 76'(adc_ch), 76'(34));
        waitRsp(0, vc);
        checkOutput("late_ack_latency", 76'(vc), 76'(ack + D + 1));
        checkOutput("abort_cnt_still_4", 76'(abort_cnt), 76'(4));

        // Frames that must be dropped.
        $display("[TB] foreign COB-ID and RTR frames");
        applyStimulus(11'h601, 1'b0, reqBytes(8'h40, 16'h2400, 8'h00, 32'h0), acc);
        seenValid = 0;
        seenBusy  = 0;
        for (int i = 0; i < 100; i++) begin
            if (rsp_valid) seenValid++;
            if (busy) seenBusy++;
            tick();
        end
        checkOutput("wrong_cob_rsp_valid", 76'(seenValid), 76'(0));
        checkOutput("wrong_cob_busy", 76'(seenBusy), 76'(0));
        applyStimulus(11'h63F, 1'b1, reqBytes(8'h40, 16'h2400, 8'h00, 32'h0), acc);
        seenValid = 0;
        seenBusy  = 0;
        for (int i = 0; i < 100; i++) begin
            if (rsp_valid) seenValid++;
            if (busy) seenBusy++;
            tick();
        end
        checkOutput("rtr_rsp_valid", 76'(seenValid), 76'(0));
        checkOutput("rtr_busy", 76'(seenBusy), 76'(0));

        // Reset in the middle of an ADC fetch.
        $display("[TB] reset during ADC wait");
        applyStimulus(11'h63F, 1'b0, reqBytes(8'h40, 16'h2400, 8'h02, 32'h0), acc);
        tick();
        tick();
        checkOutput("adc_req_before_reset", 76'(adc_req), 76'(1));
        rst = 1'b1;
        #1;
        checkResetValues("midreset");
        tick();
        rst = 1'b0;
        seenValid = 0;
        for (int i = 0; i < 30; i++) begin
            if (rsp_valid) seenValid++;
            tick();
        end
        checkOutput("no_rsp_after_reset", 76'(seenValid), 76'(0));
        expQ.push_back(rspFrame(8'h43, 16'h2200, 8'h00, 32'h0));
        applyStimulus(11'h63F, 1'b0, reqBytes(8'h40, 16'h2200, 8'h00, 32'h0), acc);
        waitRsp(0, vc);
        checkOutput("scoreboard_drained", 76'(expQ.size()), 76'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mops_sdo_responder.md
# mops_sdo_responder

Emulated MOPS-side CANopen SDO responder for the mopshub_testbench data generator. It accepts one decoded 76-bit CAN request frame addressed to its node and runs an expedited upload/download transaction against a small object dictionary. It fetches ADC samples through a request/acknowledge port and returns one 76-bit response frame towards the CAN encoder of the emulated bus. MOPSHUB is the SDO initiator; this block is the answering end.

## Interface
- NODE_ID, 7'h3F: CANopen node id; request COB-ID 0x600+NODE_ID, response COB-ID 0x580+NODE_ID.
- N_ADC_CH, 6'd35: number of ADC channels mapped at index 0x2400, sub 1..N_ADC_CH.
- RESP_DELAY, 16'd8: cycles inserted between response ready and rsp_valid (chip turnaround emulation); 0 allowed.
- ADC_TIMEOUT, 16'd1000: cycles to wait for adc_ack before aborting.
- Clocking and reset: one clock; reset is asynchronous and active-high.
- clk in 1: block clock (clk_40_m domain).
- rst in 1: asynchronous, active-high reset.
- req_data in 76: frame; [75:65] COB-ID, [64] RTR, [63:0] bytes 0..7, byte0 at [63:56].
- req_valid in 1 / req_ready out 1: request handshake.
- rsp_data out 76: response frame, same layout, RTR=0.
- rsp_valid out 1 / rsp_ready in 1: response handshake.
- adc_req out 1, adc_ch out 6, adc_ack in 1, adc_val in 12: ADC fetch handshake.
- busy out 1: high in any state other than IDLE.
- abort_cnt out 8: saturating count of abort responses sent.

## Operation
- States: IDLE, DECODE, ADC_WAIT, DELAY, SEND.
- IDLE: req_ready=1. Accept on req_valid&&req_ready and latch the frame. Go to DECODE if COB-ID==0x600+NODE_ID and RTR==0. Otherwise drop the frame and stay in IDLE.
- DECODE: index = {byte2,byte1}, sub = byte3, cmd = byte0. The response template echoes bytes 1..3. Unused bytes are 0.
  - cmd 0x40 (upload), index 0x2400, sub 0: response 0x4F, byte4=N_ADC_CH. Go to DELAY.
  - cmd 0x40, index 0x2400, sub 1..N_ADC_CH: adc_ch=sub-1. Go to ADC_WAIT.
  - cmd 0x40, index 0x2200, sub 0: response 0x43, bytes4..7 = scratch register, little-endian. Go to DELAY.
  - cmd 0x23 (download 4 bytes), index 0x2200, sub 0: scratch <= bytes4..7 (little-endian). Response 0x60. Go to DELAY.
  - Unknown index: abort 0x06020000. Known index with bad sub: abort 0x06090011. Other cmd: abort 0x05040001.
  - Abort response: byte0=0x80, bytes4..7 = code, little-endian. abort_cnt increments on SEND.
- ADC_WAIT: adc_req held high.
  - On adc_ack: response 0x4B, byte4=adc_val[7:0], byte5={4'h0,adc_val[11:8]}. Go to DELAY.
  - At ADC_TIMEOUT cycles without adc_ack: abort 0x08000000. Go to DELAY.
- DELAY: count RESP_DELAY cycles, then go to SEND. With RESP_DELAY=0, go to SEND the next cycle.
- SEND: rsp_valid=1 and rsp_data stable until rsp_ready. On the handshake cycle, go to IDLE.
- Scratch register resets to 32'h0.

## Timing
- Reset values: req_ready=1, rsp_valid=0, rsp_data=0, adc_req=0, adc_ch=0, busy=0, abort_cnt=0. State IDLE.
- Cycle 0 = accept. Cycle 1 = DECODE. Non-ADC path: rsp_valid rises at cycle 2+RESP_DELAY.
- ADC path: adc_req rises at cycle 2 and falls the cycle after adc_ack is sampled. rsp_valid rises RESP_DELAY+1 cycles after the ack cycle.
- adc_ack arriving in the same cycle as the timeout: the ack wins.
- req_ready=0 whenever busy. Requests are never queued.
- rst mid-transaction: immediate return to reset values. The scratch register is cleared. No response is emitted.
- abort_cnt saturates at 8'hFF.

## Structure
- Shared package mops_sdo_pkg holds:
  - state enum;
  - frame field slice constants;
  - SDO command constants (0x40, 0x23, 0x43, 0x4B, 0x4F, 0x60, 0x80);
  - abort codes;
  - OD index constants 0x2400 and 0x2200.
- One sub-module, mops_od_lookup: combinational. Inputs cmd/index/sub. Outputs action (ADC, const, scratch read, scratch write, abort) and abort code.

## Test plan
- Reset, then req 0x63F cmd 0x40 idx 0x2400 sub 0x05, adc_ack after 3 cycles with adc_val=0xABC -> adc_ch=4; rsp COB 0x5BF, bytes 4B 00 24 05 BC 0A 00 00; latency matches formula.
- Download 0x23 idx 0x2200 data 0xDEADBEEF, then upload -> first rsp byte0=0x60; second rsp 43 00 22 00 EF BE AD DE.
- Upload idx 0x1234 -> 80 34 12 00 00 00 02 06, abort_cnt=1. Upload 0x2400 sub 36 -> abort 0x06090011. cmd 0x60 -> abort 0x05040001.
- No adc_ack -> abort 0x08000000 after exactly ADC_TIMEOUT cycles in ADC_WAIT. Then a repeat with the ack coinciding with the timeout -> normal 0x4B response.
- Wrong COB-ID 0x601, or RTR=1 -> no rsp_valid for 100 cycles, busy stays 0.
- Hold rsp_ready low 20 cycles -> rsp_data stable and req_ready=0. Assert rst during ADC_WAIT -> outputs return to reset values, no response, scratch reads 0.
